mem_request_seq: RTL and testbench

Request sequencer sitting directly upstream of the `memory` block (the 4-line LRU write-back cache in front of `ramlpm`). It accepts one read/write request at a time from the user-side logic over a ready/valid handshake and drives the cache's `address`/`data`/`wren` inputs. It waits for the cache's level-style `valid` and returns the read data with a hit/miss tag. It also keeps saturating hit/miss counters for the board display.

---
 rtl/mem_request_seq_if.sv | 50 +++++
 rtl/mem_request_seq.sv | 179 +++++++++++++++++
 tb/tb_mem_request_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_request_seq_if.sv
// mem_request_seq_if
// Groups every signal between the request sequencer and its neighbours:
//   req_* : user-side request channel (valid/ready)
//   mem_* : drive/return signals of the LRU write-back cache
//   rsp_* : one-cycle response pulse back to the user side
//   hit_count / miss_count : saturating statistics for the board display
// Modports:
//   slave  : the sequencer's view (accepts requests, drives the cache)
//   master : the environment's view (issues requests, models the cache)
//
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both 1. req_* are sampled only on that edge. rsp_valid is
// a one-cycle pulse with no back-pressure; rsp_data/rsp_hit/rsp_error are
// meaningful only while it is high.
interface mem_request_seq_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wren;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_data;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  mem_valid;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_hit;
  logic                  rsp_error;

  logic [7:0]            hit_count;
  logic [7:0]            miss_count;

  modport slave (
    input  req_valid, req_wren, req_address, req_data, mem_q, mem_valid,
    output req_ready, mem_address, mem_data, mem_wren,
           rsp_valid, rsp_data, rsp_hit, rsp_error, hit_count, miss_count
  );

  modport master (
    output req_valid, req_wren, req_address, req_data, mem_q, mem_valid,
    input  req_ready, mem_address, mem_data, mem_wren,
           rsp_valid, rsp_data, rsp_hit, rsp_error, hit_count, miss_count
  );
endinterface

// File: rtl/mem_request_seq.sv
// mem_request_seq
// Request sequencer upstream of the 4-line LRU write-back cache. Accepts one
// read/write request at a time, drives the cache address/data/wren from
// registers, waits for the cache's level-style valid and returns the data
// tagged hit/miss (or error on timeout). Keeps saturating hit/miss counters.
// Ports:
//   clock     : sole clock, posedge
//   reset     : synchronous, active-high
//   bus       : mem_request_seq_if.slave (req_*, mem_*, rsp_*, counters)
//   dbg_state : current FSM state (IDLE=0 GUARD=1 SETTLE=2 WAIT=3 RESP=4)
// TIMEOUT must lie in 3..15 (the latency counter is 4 bits wide).
module mem_request_seq #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_request_seq_if.slave     bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GUARD  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_wren_q, mem_wren_d;
  logic [ADDR_WIDTH-1:0] lreq_address_q, lreq_address_d;
  logic [DATA_WIDTH-1:0] lreq_data_q, lreq_data_d;
  logic                  lreq_wren_q, lreq_wren_d;
  logic [3:0]            lat_q, lat_d;
  logic                  guard_q, guard_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [7:0]            hit_count_q, hit_count_d;
  logic [7:0]            miss_count_q, miss_count_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      mem_address_q  <= '0;
      mem_data_q     <= '0;
      mem_wren_q     <= 1'b0;
      lreq_address_q <= '0;
      lreq_data_q    <= '0;
      lreq_wren_q    <= 1'b0;
      lat_q          <= '0;
      guard_q        <= 1'b0;
      rsp_data_q     <= '0;
      rsp_hit_q      <= 1'b0;
      rsp_error_q    <= 1'b0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      mem_address_q  <= mem_address_d;
      mem_data_q     <= mem_data_d;
      mem_wren_q     <= mem_wren_d;
      lreq_address_q <= lreq_address_d;
      lreq_data_q    <= lreq_data_d;
      lreq_wren_q    <= lreq_wren_d;
      lat_q          <= lat_d;
      guard_q        <= guard_d;
      rsp_data_q     <= rsp_data_d;
      rsp_hit_q      <= rsp_hit_d;
      rsp_error_q    <= rsp_error_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mem_address_d  = mem_address_q;
    mem_data_d     = mem_data_q;
    mem_wren_d     = mem_wren_q;
    lreq_address_d = lreq_address_q;
    lreq_data_d    = lreq_data_q;
    lreq_wren_d    = lreq_wren_q;
    lat_d          = lat_q;
    guard_d        = guard_q;
    rsp_data_d     = rsp_data_q;
    rsp_hit_d      = rsp_hit_q;
    rsp_error_d    = rsp_error_q;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          lreq_address_d = bus.req_address;
          lreq_data_d    = bus.req_data;
          lreq_wren_d    = bus.req_wren;
          // The cache only starts an access when address or wren changes,
          // so an identical request must first be separated by a dummy read.
          if (bus.req_address == mem_address_q && bus.req_wren == mem_wren_q) begin
            state_d = S_GUARD;
          end else begin
            mem_address_d = bus.req_address;
            mem_data_d    = bus.req_data;
            mem_wren_d    = bus.req_wren;
            lat_d         = '0;
            state_d       = S_SETTLE;
          end
        end
      end
      S_GUARD: begin
        mem_address_d = mem_address_q ^ ADDR_WIDTH'(1);
        mem_wren_d    = 1'b0;
        lat_d         = '0;
        guard_d       = 1'b1;
        state_d       = S_SETTLE;
      end
      S_SETTLE: begin
        // The cache's valid still reflects the previous access here.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_valid) begin
          if (guard_q) begin
            guard_d       = 1'b0;
            mem_address_d = lreq_address_q;
            mem_data_d    = lreq_data_q;
            mem_wren_d    = lreq_wren_q;
            lat_d         = '0;
            state_d       = S_SETTLE;
          end else begin
            rsp_data_d  = bus.mem_q;
            rsp_hit_d   = (lat_q == 4'd0);
            rsp_error_d = 1'b0;
            state_d     = S_RESP;
          end
        end else if (lat_q == LAT_LAST) begin
          rsp_data_d  = '0;
          rsp_hit_d   = 1'b0;
          rsp_error_d = 1'b1;
          guard_d     = 1'b0;
          state_d     = S_RESP;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      S_RESP: begin
        if (!rsp_error_q) begin
          if (rsp_hit_q) begin
            if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
          end else begin
            if (miss_count_q != 8'hFF) miss_count_d = miss_count_q + 8'd1;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_wren    = mem_wren_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_hit     = rsp_hit_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.hit_count   = hit_count_q;
  assign bus.miss_count  = miss_count_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_request_seq.sv
// tb_mem_request_seq
// Directed bench for mem_request_seq with a small behavioural cache model
// (programmable latency, or never-valid) and an expected-data queue.
module tb_mem_request_seq;

  localparam int AW = 5;
  localparam int DW = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;

  mem_request_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_request_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(15)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- cache model ----------------
  // A new access starts when address/wren changes; valid drops and rises
  // again model_lat edges after the change is first seen.
  logic [DW-1:0] model_mem [32];
  int            model_lat   = 1;
  bit            model_dead  = 1'b0;
  logic [AW-1:0] last_addr   = '0;
  logic          last_wren   = 1'b0;
  logic          model_valid = 1'b1;
  logic [DW-1:0] model_q     = '0;
  int            model_cnt   = 0;

  assign bus.mem_valid = model_valid;
  assign bus.mem_q     = model_q;

  always @(posedge clock) begin
    if (bus.mem_address != last_addr || bus.mem_wren != last_wren) begin
      last_addr <= bus.mem_address;
      last_wren <= bus.mem_wren;
      if (bus.mem_wren) model_mem[bus.mem_address] <= bus.mem_data;
      if (model_dead) begin
        model_valid <= 1'b0;
        model_cnt   <= 0;
      end else if (model_lat == 1) begin
        model_valid <= 1'b1;
        model_q     <= bus.mem_wren ? bus.mem_data : model_mem[bus.mem_address];
        model_cnt   <= 0;
      end else begin
        model_valid <= 1'b0;
        model_cnt   <= model_lat - 1;
      end
    end else if (model_cnt > 1) begin
      model_cnt <= model_cnt - 1;
    end else if (model_cnt == 1) begin
      model_valid <= 1'b1;
      model_q     <= model_mem[last_addr];
      model_cnt   <= 0;
    end
  end

  // ---------------- monitors ----------------
  int rsp_pulses = 0;
  bit saw_guard  = 1'b0;
  logic [AW-1:0] guard_addr = '0;

  always @(negedge clock) begin
    if (bus.rsp_valid) rsp_pulses++;
    if (bus.mem_address == guard_addr && !bus.mem_wren && dbg_state != 3'd0)
      saw_guard = 1'b1;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request, waits (bounded) for the response pulse and checks it.
  // edges counts the accept edge as 1.
  task automatic do_req(input string tag, input logic wren, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [DW-1:0] exp_data,
                        input logic exp_hit, input logic exp_err, input int exp_edges);
    int  edges;
    bit  found;
    logic [DW-1:0] e;
    exp_q.push_back(exp_data);
    @(negedge clock);
    bus.req_valid   = 1'b1;
    bus.req_wren    = wren;
    bus.req_address = addr;
    bus.req_data    = data;
    @(posedge clock);
    #1;
    // Later changes to req_* must be ignored.
    bus.req_valid   = 1'b0;
    bus.req_address = ~addr;
    bus.req_data    = ~data;
    bus.req_wren    = ~wren;
    check({tag, "_ready_low"}, 32'(bus.req_ready), 32'd0);
    edges = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clock);
      #1;
      edges++;
      if (bus.rsp_valid) found = 1'b1;
    end
    check({tag, "_rsp_seen"}, 32'(found), 32'd1);
    e = exp_q.pop_front();
    if (found) begin
      check({tag, "_edges"}, 32'(edges), 32'(exp_edges));
      check({tag, "_data"},  32'(bus.rsp_data),  32'(e));
      check({tag, "_hit"},   32'(bus.rsp_hit),   32'(exp_hit));
      check({tag, "_err"},   32'(bus.rsp_error), 32'(exp_err));
    end
    @(posedge clock);
    #1;
    check({tag, "_rsp_one_cycle"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_ready_back"},    32'(bus.req_ready), 32'd1);
  endtask

  // Quiet hit request used to fill the hit counter.
  task automatic quick_hit(input logic [AW-1:0] addr);
    @(negedge clock);
    bus.req_valid   = 1'b1;
    bus.req_wren    = 1'b0;
    bus.req_address = addr;
    bus.req_data    = '0;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 40 && !bus.req_ready; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  int pulses_before;

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_wren    = 1'b0;
    bus.req_address = '0;
    bus.req_data    = '0;
    for (int i = 0; i < 32; i++) model_mem[i] = 8'(i * 3);
    model_mem[2] = 8'h01;
    model_mem[7] = 8'hA5;
    model_mem[1] = 8'h03;
    model_mem[0] = 8'h5A;

    repeat (3) @(posedge clock);
    #1;
    check("rst_ready",    32'(bus.req_ready),   32'd1);
    check("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    check("rst_mem_data", 32'(bus.mem_data),    32'd0);
    check("rst_mem_wren", 32'(bus.mem_wren),    32'd0);
    check("rst_rsp",      32'({bus.rsp_valid, bus.rsp_hit, bus.rsp_error, bus.rsp_data}), 32'd0);
    check("rst_counts",   32'({bus.hit_count, bus.miss_count}), 32'd0);
    check("rst_state",    32'(dbg_state), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Latency-1 read hit.
    model_lat = 1;
    do_req("rd_hit", 1'b0, 5'h02, 8'h00, 8'h01, 1'b1, 1'b0, 3);
    check("rd_hit_hitcnt", 32'(bus.hit_count), 32'd1);

    // Latency-4 read miss.
    model_lat = 4;
    do_req("rd_miss", 1'b0, 5'h07, 8'h00, 8'hA5, 1'b0, 1'b0, 6);
    check("rd_miss_misscnt", 32'(bus.miss_count), 32'd1);
    check("rd_miss_hitcnt",  32'(bus.hit_count),  32'd1);

    // Two identical writes: second one goes through a guard read of 0x02.
    model_lat = 1;
    pulses_before = rsp_pulses;
    do_req("wr1", 1'b1, 5'h03, 8'h3C, 8'h3C, 1'b1, 1'b0, 3);
    guard_addr = 5'h02;
    saw_guard  = 1'b0;
    do_req("wr2", 1'b1, 5'h03, 8'h7E, 8'h7E, 1'b1, 1'b0, 6);
    check("wr2_guard_seen", 32'(saw_guard), 32'd1);
    check("wr2_mem_data",   32'(bus.mem_data), 32'h7E);
    check("wr2_mem_addr",   32'(bus.mem_address), 32'h03);
    check("wr_pulses",      32'(rsp_pulses - pulses_before), 32'd2);
    check("wr_hitcnt",      32'(bus.hit_count), 32'd3);

    // Timeout: cache never valid.
    model_dead = 1'b1;
    do_req("tmo", 1'b0, 5'h05, 8'h00, 8'h00, 1'b0, 1'b1, 17);
    check("tmo_hitcnt",  32'(bus.hit_count),  32'd3);
    check("tmo_misscnt", 32'(bus.miss_count), 32'd1);

    // Saturate the hit counter (alternating addresses avoid the guard path).
    model_dead = 1'b0;
    model_lat  = 1;
    for (int i = 0; i < 260; i++) quick_hit((i % 2 == 0) ? 5'h02 : 5'h04);
    check("sat_hitcnt", 32'(bus.hit_count), 32'd255);
    do_req("sat_more", 1'b0, 5'h02, 8'h00, 8'h01, 1'b1, 1'b0, 3);
    check("sat_hitcnt_hold", 32'(bus.hit_count), 32'd255);
    do_req("rd_01", 1'b0, 5'h01, 8'h00, 8'h03, 1'b1, 1'b0, 3);

    // Reset while waiting: no response, everything back to reset values.
    model_dead = 1'b1;
    pulses_before = rsp_pulses;
    @(negedge clock);
    bus.req_valid   = 1'b1;
    bus.req_wren    = 1'b0;
    bus.req_address = 5'h09;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rstw_in_wait", 32'(dbg_state), 32'd3);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rstw_ready",  32'(bus.req_ready), 32'd1);
    check("rstw_mem",    32'({bus.mem_address, bus.mem_data, bus.mem_wren}), 32'd0);
    check("rstw_rsp",    32'({bus.rsp_valid, bus.rsp_hit, bus.rsp_error, bus.rsp_data}), 32'd0);
    check("rstw_counts", 32'({bus.hit_count, bus.miss_count}), 32'd0);
    check("rstw_state",  32'(dbg_state), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check("rstw_no_pulse", 32'(rsp_pulses - pulses_before), 32'd0);

    // First request after reset to (0, read) takes the guard path via 0x01.
    model_dead = 1'b0;
    guard_addr = 5'h01;
    saw_guard  = 1'b0;
    do_req("post_rst_rd0", 1'b0, 5'h00, 8'h00, 8'h5A, 1'b1, 1'b0, 6);
    check("post_rst_guard", 32'(saw_guard), 32'd1);
    check("post_rst_hitcnt", 32'(bus.hit_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
